if_stage: RTL

Instruction-fetch stage for the 5-stage RV32I pipeline: owns the program counter, issues requests to instruction memory over a request/grant/valid handshake, and loads the IF/ID pipeline register. It sits directly upstream of the hazard unit and consumes that unit's stall and flush controls (`pc_write`, `if_id_write`, `flush`) together with the EX-stage branch redirect. It supports one outstanding memory request and buffers a returned instruction while IF/ID is stalled.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/if_id_reg.sv | 45 ++++
 rtl/if_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline definitions: machine width, canonical NOP and the
// instruction-fetch state encoding.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load; a load without a delivered
// instruction inserts a bubble (valid = 0, NOP).
module if_id_reg #(
    parameter int unsigned XLEN = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic            deliver,
    input  logic [XLEN-1:0] dlv_pc,
    input  logic [XLEN-1:0] dlv_instr,
    input  logic            dlv_misalign,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            valid,
    output logic            misalign
);
    import cpu_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            instr    <= XLEN'(NOP_INSTR);
            valid    <= 1'b0;
            misalign <= 1'b0;
        end else if (flush) begin
            instr    <= XLEN'(NOP_INSTR);
            valid    <= 1'b0;
            misalign <= 1'b0;
        end else if (load) begin
            if (deliver) begin
                pc       <= dlv_pc;
                instr    <= dlv_instr;
                valid    <= 1'b1;
                misalign <= dlv_misalign;
            end else begin
                instr    <= XLEN'(NOP_INSTR);
                valid    <= 1'b0;
                misalign <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, hold buffer
// for stalled responses. Optional macro IF_MISALIGN_TRAP_EN enables the FAULT path.
module if_stage #(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            if_id_write,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            if_id_misalign
);
    import cpu_pkg::*;

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] hold_instr, hold_instr_d;
    logic            kill, kill_d;
    logic            fault_pend, fault_pend_d;

    logic            deliver;
    logic [XLEN-1:0] dlv_instr;
    logic            dlv_misalign;
    logic            outstanding;
    logic            tgt_misaligned;

`ifdef IF_MISALIGN_TRAP_EN
    assign tgt_misaligned = |branch_target[1:0];
`else
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^branch_target[1:0];
    assign tgt_misaligned  = 1'b0;
`endif

    // Request side is decoded straight from state and PC.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            pc         <= RESET_PC;
            hold_instr <= '0;
            kill       <= 1'b0;
            fault_pend <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            hold_instr <= hold_instr_d;
            kill       <= kill_d;
            fault_pend <= fault_pend_d;
        end
    end

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        hold_instr_d = hold_instr;
        kill_d       = kill;
        fault_pend_d = fault_pend;
        deliver      = 1'b0;
        dlv_instr    = hold_instr;
        dlv_misalign = 1'b0;

        // A response landing this very cycle closes the transaction, so it needs no kill.
        outstanding = ((state == WAIT) && !imem_rvalid)
                    || ((state == REQ) && imem_gnt)
                    || (kill && !imem_rvalid);

        if (branch_taken) begin
            kill_d       = outstanding;
            fault_pend_d = 1'b0;
            if (tgt_misaligned) begin
                pc_d         = branch_target;
                state_d      = FAULT;
                fault_pend_d = 1'b1;
            end else begin
                pc_d    = {branch_target[XLEN-1:2], 2'b00};
                state_d = outstanding ? WAIT : REQ;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else if (if_id_write) begin
                            deliver   = 1'b1;
                            dlv_instr = imem_rdata;
                            state_d   = REQ;
                            if (pc_write) pc_d = pc + XLEN'(4);
                        end else begin
                            hold_instr_d = imem_rdata;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (if_id_write) begin
                        deliver = 1'b1;
                        state_d = REQ;
                        if (pc_write) pc_d = pc + XLEN'(4);
                    end
                end
`ifdef IF_MISALIGN_TRAP_EN
                FAULT: begin
                    if (kill && imem_rvalid) kill_d = 1'b0;
                    if (fault_pend && if_id_write) begin
                        deliver      = 1'b1;
                        dlv_instr    = XLEN'(NOP_INSTR);
                        dlv_misalign = 1'b1;
                        fault_pend_d = 1'b0;
                    end
                end
`endif
                default: state_d = REQ;
            endcase
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (if_id_write),
        .flush        (flush),
        .deliver      (deliver),
        .dlv_pc       (pc),
        .dlv_instr    (dlv_instr),
        .dlv_misalign (dlv_misalign),
        .pc           (if_id_pc),
        .instr        (if_id_instr),
        .valid        (if_id_valid),
        .misalign     (if_id_misalign)
    );

endmodule
